ps2_keymatrix: RTL and testbench
================================

Name: ps2_keymatrix

Overview:
- Upstream feeder for the mainboard keyboard inputs. Receives a raw PS/2 keyboard stream and decodes set-2 scan codes.
- Maintains the 48-bit pressed-key vector `key_state` and the alpha-lock level consumed by the key matrix logic.
- Receive-only: never drives the PS/2 lines. Sits in the top level between the PS/2 pins and the mainboard.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before `ps2_clk` is accepted as changed.
- TIMEOUT_BITS, 15: width of the inter-edge watchdog. A partial frame is abandoned after 2^TIMEOUT_BITS clk cycles without a `ps2_clk` falling edge.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk.
- clear_keys  in  1  synchronous request; clears `key_state` and decoder prefix state.
- key_state  out  [0:47]  1 = key pressed; index = 8*column + row.
- alpha_state  out  1  alpha lock engaged.
- scan_code  out  [0:7]  last accepted byte; bit 0 = MSB.
- scan_valid  out  1  one-cycle strobe when `scan_code` updates.
- rx_error  out  1  one-cycle strobe on framing, parity or timeout error.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, receiver IDLE, decoder flags cleared, filter and watchdog counters cleared.
- Input synchronization:
  - Both inputs pass through two flip-flops.
  - `ps2_clk` is then filtered: the filtered level changes only after FILTER_LEN identical consecutive samples.
  - Falling edge = filtered level was 1 last cycle and is 0 this cycle (one-cycle `fall` pulse).
  - Data is sampled from synchronized `ps2_data` in the cycle of `fall`.
- Receiver FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on `fall` with data=0, go to DATA with bit count 0. On `fall` with data=1, stay in IDLE (spurious; no error).
  - DATA: shift data LSB-first into an 8-bit register. After the 8th bit, go to PARITY.
  - PARITY: latch the bit, go to STOP.
  - STOP: on `fall`, if stop=1 and the 9 bits (8 data + parity) have odd total parity, accept the byte; otherwise pulse `rx_error`. Return to IDLE either way.
  - Watchdog: resets on every `fall` and counts while not IDLE. On terminal count, pulse `rx_error` and return to IDLE.
- Byte timing: for the `fall` of the stop bit at cycle N, `scan_code` and `scan_valid` update at N+1, and `key_state`/`alpha_state` update at N+2.
- Decoder, acting on each accepted byte:
  - 0xE0: set `ext` flag.
  - 0xF0: set `brk` flag.
  - 0xAA, 0xFA, 0xEE, 0xFE, 0x00, 0xFF: ignored; flags unchanged.
  - Any other byte is a final code:
    - If `ext` is set, it is ignored.
    - Else, look up the keymap. A valid entry sets `key_state[idx]` (make) or clears it (`brk`).
    - 0x58 (Caps Lock) toggles `alpha_state` on make only, and only if `caps_held` = 0. Make sets `caps_held`; break clears it, so typematic repeats do not toggle.
    - Unmapped codes change nothing.
    - `ext` and `brk` clear after every final code.
  - Error strobe: clears `ext` and `brk`; `key_state` is unchanged.
- `clear_keys`: next cycle, `key_state` = 0 and `ext`, `brk`, `caps_held` = 0. `alpha_state` and the receiver are unaffected. If an update lands in the same cycle, the clear wins.
- Repeated make of an already-pressed key leaves it pressed (idempotent); break of a released key is a no-op.
- Reset asserted mid-frame: the frame is discarded; after release, the receiver waits for a new start bit.

Decomposition:
- Package `ps2_keymap_pkg`:
  - Receiver state enum.
  - Special-code constants (E0, F0, 58, ignore list).
  - The 128-entry keymap table of {valid, idx[5:0]}.
  - Required entries: 0x29 Space → 1, 0x5A Enter → 2, 0x1C A → 13, 0x1B S → 21, 0x16 '1' → 36.
- One sub-module, `ps2_rx`: synchronizers, filter, frame FSM and watchdog. Its outputs are byte, valid and error.
- The top level holds the decoder and the key registers.

Test Plan:
- Frame 0x1C (bits 0,00111000,0 (parity, odd),1) at 12.5 kHz → `scan_code`=0x1C with `scan_valid` 1 cycle; `key_state[13]`=1, all other bits 0. Then F0,1C → `key_state[13]`=0.
- 0x5A with parity bit flipped → `rx_error` pulse, no `scan_valid`, `key_state` unchanged. The next valid 0x29 sets `key_state[1]`.
- Sequence 58, 58, 58, F0, 58 (make plus typematic repeats, then break) → `alpha_state` 0→1 once. A second make/break cycle returns it to 0.
- E0, 1C then E0, F0, 1C → `key_state` unchanged, no errors. A following plain 1C sets bit 13 (`ext` cleared).
- Stop `ps2_clk` after 4 data bits for more than 2^TIMEOUT_BITS cycles → `rx_error` pulse. A complete 0x16 frame afterwards sets `key_state[36]`.
- Hold keys 13 and 21, assert `clear_keys` in the same cycle as a byte update → `key_state`=0. Also pulse `reset_n` low mid-frame → all outputs 0 and the next full frame decodes correctly.
- Glitch `ps2_clk` low for FILTER_LEN−1 cycles → no bit is consumed.

Source files
------------

// File: rtl/ps2_keymap_pkg.sv
// rtl/ps2_keymap_pkg.sv - receiver states, special scan codes and set-2 keymap
package ps2_keymap_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  localparam logic [7:0] CODE_EXT  = 8'hE0;
  localparam logic [7:0] CODE_BRK  = 8'hF0;
  localparam logic [7:0] CODE_CAPS = 8'h58;

  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
  } keymap_entry_t;

  // Keyboard housekeeping replies (BAT ok, ack, echo, resend, overrun).
  function automatic logic is_ignored(input logic [7:0] code);
    return code inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

  // 128-entry set-2 table; idx = 8*column + row of the mainboard matrix.
  // Caps Lock is deliberately absent: it drives alpha_state, not a matrix bit.
  function automatic keymap_entry_t keymap_lookup(input logic [7:0] code);
    keymap_entry_t e;
    e = '{valid: 1'b0, idx: 6'd0};
    if (!code[7]) begin
      case (code[6:0])
        7'h29: e = '{valid: 1'b1, idx: 6'd1};   // Space
        7'h5A: e = '{valid: 1'b1, idx: 6'd2};   // Enter
        7'h12: e = '{valid: 1'b1, idx: 6'd8};   // Left shift
        7'h1C: e = '{valid: 1'b1, idx: 6'd13};  // A
        7'h15: e = '{valid: 1'b1, idx: 6'd14};  // Q
        7'h1B: e = '{valid: 1'b1, idx: 6'd21};  // S
        7'h1D: e = '{valid: 1'b1, idx: 6'd22};  // W
        7'h24: e = '{valid: 1'b1, idx: 6'd30};  // E
        7'h16: e = '{valid: 1'b1, idx: 6'd36};  // 1
        7'h1E: e = '{valid: 1'b1, idx: 6'd37};  // 2
        7'h26: e = '{valid: 1'b1, idx: 6'd38};  // 3
        7'h76: e = '{valid: 1'b1, idx: 6'd40};  // Esc
        7'h66: e = '{valid: 1'b1, idx: 6'd47};  // Backspace
        default: e = '{valid: 1'b0, idx: 6'd0};
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/ps2_keymatrix_if.sv
// rtl/ps2_keymatrix_if.sv - PS/2 pins, clear request and decoded key outputs
interface ps2_keymatrix_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic        clear_keys;
  logic [0:47] key_state;
  logic        alpha_state;
  logic [0:7]  scan_code;
  logic        scan_valid;
  logic        rx_error;

  modport slave (
    input  ps2_clk, ps2_data, clear_keys,
    output key_state, alpha_state, scan_code, scan_valid, rx_error
  );

  modport master (
    output ps2_clk, ps2_data, clear_keys,
    input  key_state, alpha_state, scan_code, scan_valid, rx_error
  );
endinterface

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 synchronizer, clock glitch filter, frame FSM and watchdog
module ps2_rx
  import ps2_keymap_pkg::*;
#(
  parameter int FILTER_LEN   = 8,
  parameter int TIMEOUT_BITS = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error
);
  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic [1:0]              clk_sync_q, clk_sync_d;
  logic [1:0]              data_sync_q, data_sync_d;
  logic                    filt_q, filt_d;
  logic                    filt_prev_q, filt_prev_d;
  logic [FCW-1:0]          fcnt_q, fcnt_d;
  rx_state_e               state_q, state_d;
  logic [2:0]              bcnt_q, bcnt_d;
  logic [7:0]              shreg_q, shreg_d;
  logic                    par_q, par_d;
  logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
  logic [7:0]              byte_q, byte_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    fall;
  logic                    din;

  assign fall     = filt_prev_q & ~filt_q;
  assign din      = data_sync_q[1];
  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_error = err_q;

  // Two-stage synchronizers; the filtered clock only follows after FILTER_LEN disagreeing samples.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_d      = filt_q;
    filt_prev_d = filt_q;
    fcnt_d      = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Frame FSM: start, 8 data bits LSB first, odd parity, stop; watchdog abandons stalled frames.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    wd_d    = (fall || state_q == RX_IDLE) ? '0 : wd_q + 1'b1;
    case (state_q)
      RX_IDLE: begin
        if (fall && !din) begin
          state_d = RX_DATA;
          bcnt_d  = 3'd0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shreg_d = {din, shreg_q[7:1]};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == 3'd7) state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall) begin
          par_d   = din;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          if (din && (^{shreg_q, par_q})) begin
            byte_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    if (state_q != RX_IDLE && !fall && wd_q == '1) begin
      state_d = RX_IDLE;
      valid_d = 1'b0;
      err_d   = 1'b1;
    end
  end

  // Register bank; the idle PS/2 bus is high, so synchronizers and filter reset high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= RX_IDLE;
      bcnt_q      <= 3'd0;
      shreg_q     <= 8'd0;
      par_q       <= 1'b0;
      wd_q        <= '0;
      byte_q      <= 8'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      wd_q        <= wd_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: rtl/ps2_keymatrix.sv
// rtl/ps2_keymatrix.sv - set-2 scan code decoder driving the 48-key matrix and alpha lock
module ps2_keymatrix
  import ps2_keymap_pkg::*;
#(
  parameter int FILTER_LEN   = 8,
  parameter int TIMEOUT_BITS = 15
) (
  input logic            clk,
  input logic            reset_n,
  ps2_keymatrix_if.slave bus
);
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_error;
  keymap_entry_t entry;
  logic [0:47]   key_q, key_d;
  logic          alpha_q, alpha_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic          caps_held_q, caps_held_d;

  ps2_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) u_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2_clk (bus.ps2_clk),
    .ps2_data(bus.ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_error(rx_error)
  );

  assign bus.scan_code   = rx_byte;
  assign bus.scan_valid  = rx_valid;
  assign bus.rx_error    = rx_error;
  assign bus.key_state   = key_q;
  assign bus.alpha_state = alpha_q;

  // Prefix tracking and key updates per accepted byte; clear_keys overrides any same-cycle update.
  always_comb begin
    key_d       = key_q;
    alpha_d     = alpha_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    caps_held_d = caps_held_q;
    entry       = keymap_lookup(rx_byte);
    if (rx_valid) begin
      if (rx_byte == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == CODE_BRK) begin
        brk_d = 1'b1;
      end else if (!is_ignored(rx_byte)) begin
        if (!ext_q) begin
          if (entry.valid && entry.idx < 6'd48) key_d[entry.idx] = ~brk_q;
          if (rx_byte == CODE_CAPS) begin
            if (brk_q) begin
              caps_held_d = 1'b0;
            end else begin
              if (!caps_held_q) alpha_d = ~alpha_q;
              caps_held_d = 1'b1;
            end
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end else if (rx_error) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
    if (bus.clear_keys) begin
      key_d       = '0;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
      caps_held_d = 1'b0;
    end
  end

  // Decoder state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q       <= '0;
      alpha_q     <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      caps_held_q <= 1'b0;
    end else begin
      key_q       <= key_d;
      alpha_q     <= alpha_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      caps_held_q <= caps_held_d;
    end
  end
endmodule

// File: tb/tb_ps2_keymatrix.sv
// tb/tb_ps2_keymatrix.sv - self-checking bench for ps2_keymatrix
module tb_ps2_keymatrix;
  localparam int FILTER_LEN   = 8;
  localparam int TIMEOUT_BITS = 15;
  localparam int HALF         = 20;

  typedef struct {
    logic [7:0]  code;
    bit          bad_par;
    logic [0:47] exp_keys;
    bit          exp_alpha;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ps2_keymatrix_if bus ();

  ps2_keymatrix #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          n_valid = 0;
  int          n_err = 0;
  int          valid_cyc = 0;
  int          key_cyc = 0;
  logic [0:47] prev_key = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.scan_valid) begin
      n_valid   <= n_valid + 1;
      valid_cyc <= cyc;
    end
    if (bus.rx_error) n_err <= n_err + 1;
    if (bus.key_state !== prev_key) key_cyc <= cyc;
    prev_key <= bus.key_state;
  end

  // Reference model: set of pressed keys plus decoder flags.
  int         kmap[int];
  bit         m_key[48];
  bit         m_ext, m_brk, m_caps, m_alpha;
  logic [7:0] exp_sc;
  vec_t       tbl[$];
  bit         seen;
  int         v0, e0;
  logic [7:0] pool[0:25] = '{8'h29, 8'h5A, 8'h1C, 8'h1B, 8'h16, 8'h15, 8'h1D, 8'h24,
                             8'h1E, 8'h26, 8'h66, 8'h76, 8'h12, 8'hE0, 8'hF0, 8'hF0,
                             8'h58, 8'h44, 8'h4D, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00,
                             8'hFF, 8'h83};

  function automatic logic [0:47] kb(input int idx);
    logic [0:47] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:47] model_keys();
    logic [0:47] v;
    for (int i = 0; i < 48; i++) v[i] = m_key[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 48; i++) m_key[i] = 1'b0;
    m_ext = 0; m_brk = 0; m_caps = 0; m_alpha = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 48; i++) m_key[i] = 1'b0;
    m_ext = 0; m_brk = 0; m_caps = 0;
  endtask

  task automatic model_err();
    m_ext = 0; m_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] c);
    if (c == 8'hE0) m_ext = 1;
    else if (c == 8'hF0) m_brk = 1;
    else if (c inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
    end else begin
      if (!m_ext) begin
        if (kmap.exists(int'(c))) m_key[kmap[int'(c)]] = !m_brk;
        if (c == 8'h58) begin
          if (m_brk) m_caps = 0;
          else begin
            if (!m_caps) m_alpha = !m_alpha;
            m_caps = 1;
          end
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b0;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^code) ^ bad_par;
    ps2_bit(1'b0);
    for (int b = 0; b < 8; b++) ps2_bit(code[b]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    bus.ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic send_checked(input string tag, input logic [7:0] code, input bit bad_par,
                              input bit bad_stop);
    int  sv, se;
    bit  bad;
    bad = bad_par | bad_stop;
    sv  = n_valid;
    se  = n_err;
    send_frame(code, bad_par, bad_stop);
    if (bad) model_err();
    else begin
      model_byte(code);
      exp_sc = code;
    end
    check({tag, "_keys"}, bus.key_state, model_keys());
    check({tag, "_alpha"}, bus.alpha_state, m_alpha);
    check({tag, "_code"}, bus.scan_code, exp_sc);
    check({tag, "_nvalid"}, n_valid - sv, bad ? 0 : 1);
    check({tag, "_nerr"}, n_err - se, bad ? 1 : 0);
  endtask

  initial begin
    bus.ps2_clk    = 1'b1;
    bus.ps2_data   = 1'b1;
    bus.clear_keys = 1'b0;
    kmap[8'h29] = 1;  kmap[8'h5A] = 2;  kmap[8'h12] = 8;  kmap[8'h1C] = 13;
    kmap[8'h15] = 14; kmap[8'h1B] = 21; kmap[8'h1D] = 22; kmap[8'h24] = 30;
    kmap[8'h16] = 36; kmap[8'h1E] = 37; kmap[8'h26] = 38; kmap[8'h76] = 40;
    kmap[8'h66] = 47;
    model_reset();
    exp_sc = 8'h00;

    tbl.push_back('{8'h1C, 0, kb(13), 0});
    tbl.push_back('{8'hF0, 0, kb(13), 0});
    tbl.push_back('{8'h1C, 0, '0, 0});
    tbl.push_back('{8'h5A, 1, '0, 0});
    tbl.push_back('{8'h29, 0, kb(1), 0});
    tbl.push_back('{8'h58, 0, kb(1), 1});
    tbl.push_back('{8'h58, 0, kb(1), 1});
    tbl.push_back('{8'h58, 0, kb(1), 1});
    tbl.push_back('{8'hF0, 0, kb(1), 1});
    tbl.push_back('{8'h58, 0, kb(1), 1});
    tbl.push_back('{8'h58, 0, kb(1), 0});
    tbl.push_back('{8'hF0, 0, kb(1), 0});
    tbl.push_back('{8'h58, 0, kb(1), 0});
    tbl.push_back('{8'hE0, 0, kb(1), 0});
    tbl.push_back('{8'h1C, 0, kb(1), 0});
    tbl.push_back('{8'hE0, 0, kb(1), 0});
    tbl.push_back('{8'hF0, 0, kb(1), 0});
    tbl.push_back('{8'h1C, 0, kb(1), 0});
    tbl.push_back('{8'h1C, 0, kb(1) | kb(13), 0});
    tbl.push_back('{8'hF0, 0, kb(1) | kb(13), 0});
    tbl.push_back('{8'h29, 0, kb(13), 0});
    tbl.push_back('{8'h58, 0, kb(13), 1});
    tbl.push_back('{8'hF0, 0, kb(13), 1});
    tbl.push_back('{8'h58, 0, kb(13), 1});

    wait_cyc(5);
    check("rst_keys", bus.key_state, 48'h0);
    check("rst_alpha", bus.alpha_state, 0);
    check("rst_code", bus.scan_code, 0);
    check("rst_valid", bus.scan_valid, 0);
    check("rst_err", bus.rx_error, 0);
    reset_n = 1'b1;
    wait_cyc(20);

    foreach (tbl[i]) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(tbl[i].code, tbl[i].bad_par, 1'b0);
      if (tbl[i].bad_par) model_err();
      else begin
        model_byte(tbl[i].code);
        exp_sc = tbl[i].code;
      end
      check($sformatf("tbl%0d_keys", i), bus.key_state, tbl[i].exp_keys);
      check($sformatf("tbl%0d_alpha", i), bus.alpha_state, tbl[i].exp_alpha);
      check($sformatf("tbl%0d_code", i), bus.scan_code, exp_sc);
      check($sformatf("tbl%0d_nvalid", i), n_valid - v0, tbl[i].bad_par ? 0 : 1);
      check($sformatf("tbl%0d_nerr", i), n_err - e0, tbl[i].bad_par ? 1 : 0);
      if (i == 0) check("key_after_valid_lat", key_cyc - valid_cyc, 1);
    end

    // Stalled frame: watchdog must not fire early, then must fire once.
    v0 = n_valid;
    e0 = n_err;
    ps2_bit(1'b0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
    bus.ps2_data = 1'b1;
    wait_cyc((1 << TIMEOUT_BITS) - 200);
    check("to_not_early", n_err - e0, 0);
    wait_cyc(400);
    check("to_err", n_err - e0, 1);
    check("to_novalid", n_valid - v0, 0);
    model_err();
    send_checked("to_next", 8'h16, 0, 0);
    check("to_k36", bus.key_state, kb(13) | kb(36));

    // clear_keys in the same cycle as a key update.
    send_checked("cl_s", 8'h1B, 0, 0);
    check("cl_held", bus.key_state, kb(13) | kb(21) | kb(36));
    seen = 0;
    fork
      send_frame(8'h1D, 0, 0);
      begin
        for (int k = 0; k < 2000 && !seen; k++) begin
          @(negedge clk);
          if (bus.scan_valid) seen = 1;
        end
        if (seen) begin
          bus.clear_keys = 1'b1;
          @(posedge clk);
          #1;
          bus.clear_keys = 1'b0;
        end
      end
    join
    check("cl_seen", seen, 1);
    model_byte(8'h1D);
    model_clear();
    exp_sc = 8'h1D;
    check("cl_keys", bus.key_state, 48'h0);
    check("cl_alpha", bus.alpha_state, 1);
    check("cl_code", bus.scan_code, 8'h1D);

    // Clock glitch one sample short of the filter length, with data low.
    v0 = n_valid;
    e0 = n_err;
    bus.ps2_data = 1'b0;
    wait_cyc(30);
    bus.ps2_clk = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    bus.ps2_clk = 1'b1;
    wait_cyc(30);
    bus.ps2_data = 1'b1;
    wait_cyc(30);
    check("gl_nvalid", n_valid - v0, 0);
    check("gl_nerr", n_err - e0, 0);
    send_checked("gl_next", 8'h1C, 0, 0);
    check("gl_keys", bus.key_state, kb(13));

    // Reset in the middle of a frame.
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    reset_n = 1'b0;
    wait_cyc(3);
    check("mr_keys", bus.key_state, 48'h0);
    check("mr_alpha", bus.alpha_state, 0);
    check("mr_code", bus.scan_code, 0);
    check("mr_valid", bus.scan_valid, 0);
    check("mr_err", bus.rx_error, 0);
    bus.ps2_data = 1'b1;
    reset_n = 1'b1;
    model_reset();
    exp_sc = 8'h00;
    wait_cyc(50);
    send_checked("mr_next", 8'h5A, 0, 0);
    check("mr_k2", bus.key_state, kb(2));

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 9) == 0) begin
        bus.clear_keys = 1'b1;
        wait_cyc(1);
        bus.clear_keys = 1'b0;
        model_clear();
        wait_cyc(2);
      end
      send_checked($sformatf("rnd%0d", n), pool[$urandom_range(0, 25)], r < 8, r >= 8 && r < 12);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
